bintobcd_seq: RTL and testbench

Sequential binary-to-BCD converter for the calculator datapath. It takes an 11-bit signed two's-complement result and produces four display/BCD digit codes: BCD2..BCD0 hold the magnitude digits and BCD3 holds the sign position. It uses an iterative shift-add-3 (double-dabble) engine with a start/busy/done handshake. It sits between the ALU result register and the digit display/entry registers, producing the same digit coding the entry path consumes.

---
 rtl/calc_pkg.sv | 19 +
 rtl/dabble_adj.sv | 10 +
 rtl/bintobcd_seq.sv | 103 ++++++++++
 tb/tb_bintobcd_seq.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calculator datapath.
// Digit codes match the ones the entry/display path consumes.
package calc_pkg;

  localparam int          BITS      = 11;
  localparam logic [10:0] MAXMAG    = 11'd999;
  localparam logic [3:0]  NITER     = 4'd11;

  localparam logic [3:0]  DIG_BLANK = 4'b1010;
  localparam logic [3:0]  DIG_NEG   = 4'b1011;
  localparam logic [3:0]  DIG_ERR   = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } state_t;

endpackage

// File: rtl/dabble_adj.sv
// Double-dabble nibble correction: adds 3 when the BCD digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module dabble_adj (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  assign dout_o = (din_i >= 4'd5) ? 4'(din_i + 4'd3) : din_i;

endmodule

// File: rtl/bintobcd_seq.sv
// Sequential signed binary-to-BCD converter (double-dabble, one bit per cycle)
// with start/busy/done handshake and leading-zero-blanked, registered digit codes.
module bintobcd_seq
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [BITS-1:0] binin,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [3:0]      BCD0,
  output logic [3:0]      BCD1,
  output logic [3:0]      BCD2,
  output logic [3:0]      BCD3
);

  state_t          state_q;
  logic            sign_q;
  logic            big_q;
  logic [BITS-1:0] mag_q;
  logic [11:0]     scr_q;
  logic [3:0]      cnt_q;

  logic [BITS-1:0] mag_in;
  logic [11:0]     scr_adj;

  // -1024 negates to itself, which reads correctly as unsigned 1024.
  assign mag_in = binin[BITS-1] ? 11'(~binin + 11'd1) : binin;

  dabble_adj u_adj0 (.din_i(scr_q[3:0]),  .dout_o(scr_adj[3:0]));
  dabble_adj u_adj1 (.din_i(scr_q[7:4]),  .dout_o(scr_adj[7:4]));
  dabble_adj u_adj2 (.din_i(scr_q[11:8]), .dout_o(scr_adj[11:8]));

  // NOTE: every register here uses non-blocking assignment so that all
  // right-hand sides see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      BCD0    <= 4'b0000;
      BCD1    <= DIG_BLANK;
      BCD2    <= DIG_BLANK;
      BCD3    <= DIG_BLANK;
      sign_q  <= 1'b0;
      big_q   <= 1'b0;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q  <= binin[BITS-1];
            mag_q   <= mag_in;
            // The magnitude is shifted away during CONV, so range is judged now.
            big_q   <= (mag_in > MAXMAG);
            scr_q   <= '0;
            cnt_q   <= NITER;
            busy    <= 1'b1;
            state_q <= CONV;
          end
        end

        CONV: begin
          {scr_q, mag_q} <= {scr_adj[10:0], mag_q, 1'b0};
          cnt_q          <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= FIN;
          end
        end

        FIN: begin
          if (big_q) begin
            ovf  <= 1'b1;
            BCD0 <= DIG_ERR;
            BCD1 <= DIG_ERR;
            BCD2 <= DIG_ERR;
          end else begin
            ovf  <= 1'b0;
            BCD0 <= scr_q[3:0];
            BCD1 <= (scr_q[11:4] == 8'd0) ? DIG_BLANK : scr_q[7:4];
            BCD2 <= (scr_q[11:8] == 4'd0) ? DIG_BLANK : scr_q[11:8];
          end
          BCD3    <= sign_q ? DIG_NEG : DIG_BLANK;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bintobcd_seq.sv
// Directed self-checking bench for bintobcd_seq: reset state, signed values,
// range boundaries, start-while-busy and mid-conversion reset.
module tb_bintobcd_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] binin = '0;
  logic        busy, done, ovf;
  logic [3:0]  BCD0, BCD1, BCD2, BCD3;

  int total = 0;
  int bad   = 0;

  bintobcd_seq dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .binin  (binin),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .BCD0   (BCD0),
    .BCD1   (BCD1),
    .BCD2   (BCD2),
    .BCD3   (BCD3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {BCD3, BCD2, BCD1, BCD0};
  endfunction

  // Wait for done after the accepting edge; returns edges counted (cap 40).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_conv(input string tag, input logic [10:0] val,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat;
    @(negedge clk);
    binin = val;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    binin = ~val;
    check({tag, "_busy"}, busy, 1);
    wait_done(lat);
    check({tag, "_lat"}, lat, 12);
    check({tag, "_bcd"}, digits(), exp_bcd);
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_idle"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int ndone;

    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd",  digits(), 16'hAAA0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf",  ovf, 0);
    reset_n = 1'b1;

    do_conv("p123",   11'd123,              16'hA123, 1'b0);
    do_conv("m45",    11'h7D3,              16'hBA45, 1'b0);  // -45
    do_conv("zero",   11'd0,                16'hAAA0, 1'b0);
    do_conv("m7",     11'h7F9,              16'hBAA7, 1'b0);  // -7
    do_conv("p999",   11'd999,              16'hA999, 1'b0);
    do_conv("p1000",  11'd1000,             16'hAEEE, 1'b1);
    do_conv("m1024",  11'h400,              16'hBEEE, 1'b1);

    // 500 accepted, then a -1 request held during the busy window.
    @(negedge clk);
    binin = 11'd500;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    binin = 11'h7FF;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 5) check("ign_hold", digits(), 16'hBEEE);
      if (lat == 11) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("ign_lat", lat, 12);
    check("ign_bcd", digits(), 16'hA500);
    check("ign_ovf", ovf, 0);
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ign_nodone", ndone, 0);
    check("ign_busy", busy, 0);

    // Reset in the middle of converting 321.
    @(negedge clk);
    binin = 11'd321;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_bcd",  digits(), 16'hAAA0);
    check("abort_busy", busy, 0);
    check("abort_ovf",  ovf, 0);
    repeat (15) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);

    do_conv("p321", 11'd321, 16'hA321, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
